fifo_pkt_reader: RTL and testbench

Read-side packet drain for the FIFO. Lives in the R_CLK domain and pops bytes through the FIFO read port (EMPTY / RD_DATA / R_INC). It regroups them into fixed PKT_SIZE-byte packets on a valid/ready output stream, with start- and end-of-packet markers. If the FIFO underruns mid-packet for too long, the block aborts the partial packet and flags the error.

---
 rtl/fifo_pkt_reader_if.sv | 28 ++
 rtl/fifo_pkt_reader.sv | 118 +++++++++++
 tb/tb_fifo_pkt_reader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkt_reader_if.sv
// Bundle of the FIFO read port, the packet output stream and packet status for fifo_pkt_reader.
// master = the packet reader itself, slave = the FIFO plus downstream consumer.
interface fifo_pkt_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  EMPTY;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  R_INC;
  logic [DATA_WIDTH-1:0] OUT_DATA;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic                  OUT_SOP;
  logic                  OUT_EOP;
  logic                  PKT_DONE;
  logic                  PKT_ERR;
  logic [CNT_WIDTH-1:0]  PKT_COUNT;

  modport master (
    input  EMPTY, RD_DATA, OUT_READY,
    output R_INC, OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP, PKT_DONE, PKT_ERR, PKT_COUNT
  );

  modport slave (
    output EMPTY, RD_DATA, OUT_READY,
    input  R_INC, OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP, PKT_DONE, PKT_ERR, PKT_COUNT
  );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Drains a first-word-fall-through FIFO into fixed-size packets on a valid/ready stream,
// aborting a partial packet when the FIFO stays empty mid-packet for TIMEOUT cycles.
module fifo_pkt_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_SIZE   = 10,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic             R_CLK,
  input  logic             R_RST,
  fifo_pkt_reader_if.master bus
);
  localparam int IW = $clog2(PKT_SIZE);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(PKT_SIZE - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BODY, ABORT} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         stall_q, stall_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic                  pkt_done_q, pkt_done_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;

  logic load_ok, pop, accept;

  // R_INC is gated by reset so the FIFO is never popped while the reader is being cleared.
  assign load_ok = !out_valid_q || bus.OUT_READY;
  assign pop     = R_RST && !bus.EMPTY && load_ok && (state_q != ABORT);
  assign accept  = out_valid_q && bus.OUT_READY;

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stall_d     = stall_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    if (pop) begin
      out_data_d  = bus.RD_DATA;
      out_valid_d = 1'b1;
      out_sop_d   = (idx_q == '0);
      out_eop_d   = (idx_q == IDX_LAST);
      idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    // Completion is counted when the EOP beat leaves, not when it is popped.
    pkt_done_d  = accept && out_eop_q;
    pkt_count_d = pkt_done_d ? pkt_count_q + CNT_WIDTH'(1) : pkt_count_q;

    unique case (state_q)
      IDLE: begin
        stall_d = '0;
        if (pop) state_d = BODY;
      end
      BODY: begin
        if (pop) begin
          stall_d = '0;
          if (idx_q == IDX_LAST) state_d = IDLE;
        end else if (bus.EMPTY) begin
          // Backpressured cycles (EMPTY=0, no room) fall through and hold the count.
          stall_d = stall_q + SW'(1);
          if (stall_q == STALL_LAST) state_d = ABORT;
        end
      end
      ABORT: begin
        idx_d   = '0;
        stall_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge R_CLK) begin
    if (!R_RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      stall_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stall_q     <= stall_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      pkt_done_q  <= pkt_done_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign bus.R_INC     = pop;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_SOP   = out_sop_q;
  assign bus.OUT_EOP   = out_eop_q;
  assign bus.PKT_DONE  = pkt_done_q;
  assign bus.PKT_ERR   = (state_q == ABORT);
  assign bus.PKT_COUNT = pkt_count_q;
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: a queue-backed FWFT FIFO feeds the reader and
// accepted beats are logged, then compared against hand-written packet expectations.
module tb_fifo_pkt_reader;
  localparam int DW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_pkt_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fifo_pkt_reader #(
    .DATA_WIDTH(DW), .PKT_SIZE(10), .TIMEOUT(16), .CNT_WIDTH(CW)
  ) dut (
    .R_CLK (clk),
    .R_RST (rst_n),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int done_cnt   = 0;
  int err_cnt    = 0;
  bit ready      = 1'b1;
  bit last_rinc  = 1'b0;
  int bp_left    = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] got_data[$];
  bit         got_sop[$];
  bit         got_eop[$];
  int         got_cyc[$];
  logic [7:0] exp_data[$];
  bit         exp_sop[$];
  bit         exp_eop[$];

  logic [7:0] sp_bytes [10] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D,
                                8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive FIFO/ready, sample handshakes at the falling edge, commit pops after the rising edge.
  task automatic cycle();
    bit pop, acc;
    bus.EMPTY     = (fifo_q.size() == 0);
    bus.RD_DATA   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    bus.OUT_READY = ready;
    @(negedge clk);
    pop       = (bus.R_INC === 1'b1) && !bus.EMPTY;
    last_rinc = (bus.R_INC !== 1'b0);
    acc       = rst_n && (bus.OUT_VALID === 1'b1) && bus.OUT_READY;
    if (acc) begin
      got_data.push_back(bus.OUT_DATA);
      got_sop.push_back(bus.OUT_SOP);
      got_eop.push_back(bus.OUT_EOP);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop) void'(fifo_q.pop_front());
    if (bus.PKT_DONE === 1'b1) done_cnt++;
    if (bus.PKT_ERR === 1'b1) err_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic add_exp(input logic [7:0] d, input bit s, input bit e);
    exp_data.push_back(d);
    exp_sop.push_back(s);
    exp_eop.push_back(e);
  endtask

  task automatic compare(input string tag, input bit consecutive);
    int n;
    chk({tag, "_beats"}, 32'(got_data.size()), 32'(exp_data.size()));
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
      chk($sformatf("%s_sop%0d", tag, i), 32'(got_sop[i]), 32'(exp_sop[i]));
      chk($sformatf("%s_eop%0d", tag, i), 32'(got_eop[i]), 32'(exp_eop[i]));
      if (consecutive && i > 0)
        chk($sformatf("%s_gap%0d", tag, i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd1);
    end
    got_data.delete(); got_sop.delete(); got_eop.delete(); got_cyc.delete();
    exp_data.delete(); exp_sop.delete(); exp_eop.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for two edges with data waiting in the FIFO.
    rst_n = 1'b0;
    ready = 1'b1;
    foreach (sp_bytes[i]) fifo_q.push_back(sp_bytes[i]);
    bus.EMPTY = 1'b0; bus.RD_DATA = 8'h00; bus.OUT_READY = 1'b1;
    run(2);
    chk("rst_r_inc",     32'(bus.R_INC),     32'd0);
    chk("rst_out_data",  32'(bus.OUT_DATA),  32'd0);
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_out_sop",   32'(bus.OUT_SOP),   32'd0);
    chk("rst_out_eop",   32'(bus.OUT_EOP),   32'd0);
    chk("rst_pkt_done",  32'(bus.PKT_DONE),  32'd0);
    chk("rst_pkt_err",   32'(bus.PKT_ERR),   32'd0);
    chk("rst_pkt_count", 32'(bus.PKT_COUNT), 32'd0);
    chk("rst_no_pop",    32'(fifo_q.size()), 32'd10);

    // Single packet, downstream always ready.
    rst_n = 1'b1;
    run(14);
    foreach (sp_bytes[i]) add_exp(sp_bytes[i], i == 0, i == 9);
    compare("sp", 1'b1);
    chk("sp_done_cnt", 32'(done_cnt), 32'd1);
    chk("sp_count",    32'(bus.PKT_COUNT), 32'd1);

    // Backpressure: three not-ready cycles while 0x63 is on the output.
    foreach (sp_bytes[i]) fifo_q.push_back(sp_bytes[i]);
    bp_left = 3;
    repeat (20) begin
      if (bp_left > 0 && bus.OUT_VALID === 1'b1 && bus.OUT_DATA === 8'h63) begin
        ready = 1'b0;
        cycle();
        bp_left--;
        chk("bp_r_inc", 32'(last_rinc), 32'd0);
        chk("bp_hold",  32'(bus.OUT_DATA), 32'h63);
      end else begin
        ready = 1'b1;
        cycle();
      end
    end
    ready = 1'b1;
    chk("bp_applied", 32'(bp_left), 32'd0);
    foreach (sp_bytes[i]) add_exp(sp_bytes[i], i == 0, i == 9);
    compare("bp", 1'b0);
    chk("bp_done_cnt", 32'(done_cnt), 32'd2);
    chk("bp_count",    32'(bus.PKT_COUNT), 32'd2);
    chk("bp_err_cnt",  32'(err_cnt), 32'd0);

    // Underrun of 16 cycles after 5 bytes: abort on exactly the 16th empty edge.
    for (int i = 0; i < 5; i++) fifo_q.push_back(sp_bytes[i]);
    run(20);
    chk("ua_no_err_yet", 32'(bus.PKT_ERR), 32'd0);
    chk("ua_err_cnt0",   32'(err_cnt), 32'd0);
    run(1);
    chk("ua_pkt_err", 32'(bus.PKT_ERR), 32'd1);
    chk("ua_err_cnt", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'hA0 + i));
    run(1);
    chk("ua_abort_r_inc", 32'(last_rinc), 32'd0);
    chk("ua_err_pulse",   32'(bus.PKT_ERR), 32'd0);
    run(12);
    for (int i = 0; i < 5; i++) add_exp(sp_bytes[i], i == 0, 1'b0);
    for (int i = 0; i < 10; i++) add_exp(8'(8'hA0 + i), i == 0, i == 9);
    compare("ua", 1'b0);
    chk("ua_err_total", 32'(err_cnt), 32'd1);
    chk("ua_done_cnt",  32'(done_cnt), 32'd3);
    chk("ua_count",     32'(bus.PKT_COUNT), 32'd3);

    // Underrun of 15 cycles: data arrives with stall at TIMEOUT-1, no abort.
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'hB0 + i));
    run(20);
    for (int i = 5; i < 10; i++) fifo_q.push_back(8'(8'hB0 + i));
    run(1);
    chk("ub_no_err", 32'(bus.PKT_ERR), 32'd0);
    run(8);
    for (int i = 0; i < 10; i++) add_exp(8'(8'hB0 + i), i == 0, i == 9);
    compare("ub", 1'b0);
    chk("ub_err_total", 32'(err_cnt), 32'd1);
    chk("ub_done_cnt",  32'(done_cnt), 32'd4);
    chk("ub_count",     32'(bus.PKT_COUNT), 32'd4);

    // Back-to-back packets with no bubble between them.
    for (int i = 0; i < 20; i++) fifo_q.push_back(8'(8'hC0 + i));
    run(24);
    for (int i = 0; i < 20; i++) add_exp(8'(8'hC0 + i), (i % 10) == 0, (i % 10) == 9);
    compare("b2b", 1'b1);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd6);
    chk("b2b_count",    32'(bus.PKT_COUNT), 32'd6);

    // Reset after the third byte is accepted; the held fourth byte is discarded.
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'hE0 + i));
    run(4);
    rst_n = 1'b0;
    run(1);
    chk("rm_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rm_pkt_err",   32'(bus.PKT_ERR),   32'd0);
    chk("rm_count",     32'(bus.PKT_COUNT), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'hF0 + i));
    run(14);
    for (int i = 0; i < 3; i++) add_exp(8'(8'hE0 + i), i == 0, 1'b0);
    for (int i = 4; i < 10; i++) add_exp(8'(8'hE0 + i), i == 4, 1'b0);
    for (int i = 0; i < 4; i++) add_exp(8'(8'hF0 + i), 1'b0, i == 3);
    compare("rm", 1'b0);
    chk("rm_err_total", 32'(err_cnt), 32'd1);
    chk("rm_done_cnt",  32'(done_cnt), 32'd7);
    chk("rm_count_end", 32'(bus.PKT_COUNT), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
